// File: rtl/retime_pipe_valid.sv
// Retiming delay line with per-stage valid bits, global stall, synchronous flush and occupancy count.
// STAGES=0 degenerates to a combinational passthrough with no state.
module retime_pipe_valid #(
    parameter int                 WIDTH      = 40,
    parameter int                 STAGES     = 1,
    parameter logic [WIDTH-1:0]   INIT_VALUE = '0,
    parameter bit                 GATE_OUT   = 1'b0,
    localparam int                CW         = (STAGES < 1) ? 1 : $clog2(STAGES + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_flow,
    input  logic             io_flush,
    input  logic [WIDTH-1:0] io_in,
    input  logic             io_in_valid,
    output logic [WIDTH-1:0] io_out,
    output logic             io_out_valid,
    output logic [CW-1:0]    io_count,
    output logic             io_empty
);

    generate
        if (STAGES == 0) begin : g_passthrough
            // Control inputs are intentionally ignored when there is no storage.
            logic unused_ctrl;
            assign unused_ctrl  = &{1'b0, clock, reset, io_flow, io_flush};

            assign io_out       = (GATE_OUT && !io_in_valid) ? INIT_VALUE : io_in;
            assign io_out_valid = io_in_valid;
            assign io_count     = '0;
            assign io_empty     = 1'b1;
        end else begin : g_pipe
            logic [WIDTH-1:0] data_q [STAGES];
            logic [STAGES-1:0] vld_q;
            logic [CW-1:0]     count_q;

            // Reset and flush both return every stage to the idle value and drop the incoming beat.
            always_ff @(posedge clock) begin
                if (reset || io_flush) begin
                    for (int i = 0; i < STAGES; i++) begin
                        data_q[i] <= INIT_VALUE;
                    end
                    vld_q   <= '0;
                    count_q <= '0;
                end else if (io_flow) begin
                    data_q[0] <= io_in;
                    vld_q[0]  <= io_in_valid;
                    for (int i = 1; i < STAGES; i++) begin
                        data_q[i] <= data_q[i-1];
                        vld_q[i]  <= vld_q[i-1];
                    end
                    count_q <= count_q + CW'(io_in_valid) - CW'(vld_q[STAGES-1]);
                end
            end

            assign io_out_valid = vld_q[STAGES-1];
            assign io_out       = (GATE_OUT && !vld_q[STAGES-1]) ? INIT_VALUE : data_q[STAGES-1];
            assign io_count     = count_q;
            assign io_empty     = (count_q == '0);
        end
    endgenerate

endmodule
